dmem_arbiter: RTL

//   Shares the single data-memory port between two requesters:
//     - the core MEM stage (EX/MEM register outputs);
//     - a debug/loader port with a req/gnt handshake.
//   The core has priority. A starvation counter guarantees the debug port a grant after MAX_WAIT denied cycles.

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data-memory port: core MEM stage (priority) and a
// debug/loader port, with a starvation counter that eventually hands debug a turn.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic                  core_stall,
    output logic                  core_rvalid,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [0:0]       CORE_PRI = 1'b0;
    localparam logic [0:0]       DBG_PRI  = 1'b1;
    localparam logic [2:0]       F3_WORD  = 3'b010;

    logic [0:0]       pri_q, pri_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic             core_act, core_load, core_gnt, dbg_deny;

    always_comb begin
        core_act  = core_rd | core_wr;
        // rd+wr together is a store; only a pure read returns data
        core_load = core_rd & ~core_wr;
        // grants are forced off while reset is held so nothing reaches memory
        core_gnt  = reset & core_act & (~dbg_req | (pri_q == CORE_PRI));
        dbg_gnt   = reset & dbg_req & ~core_gnt;
        dbg_deny  = dbg_req & ~dbg_gnt;
        core_stall = reset & core_act & ~core_gnt;

        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_func3 = core_func3;
        if (dbg_gnt) begin
            mem_rd    = ~dbg_we;
            mem_wr    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_func3 = F3_WORD;
        end else if (core_gnt) begin
            mem_rd = core_load;
            mem_wr = core_wr;
        end

        starve_cnt_d = starve_cnt_q;
        if (dbg_gnt)
            starve_cnt_d = '0;
        else if (dbg_deny && starve_cnt_q != CNT_MAX)
            starve_cnt_d = starve_cnt_q + CNT_W'(1);

        // debug keeps its turn until it actually gets a grant
        pri_d = pri_q;
        if (pri_q == CORE_PRI) begin
            if (dbg_deny && starve_cnt_d == CNT_MAX)
                pri_d = DBG_PRI;
        end else if (dbg_gnt) begin
            pri_d = CORE_PRI;
        end

        rd_pend_d  = (core_gnt & core_load) | (dbg_gnt & ~dbg_we);
        rd_owner_d = dbg_gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pri_q        <= CORE_PRI;
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            pri_q        <= pri_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign core_rvalid = rd_pend_q & ~rd_owner_q;
    assign dbg_rvalid  = rd_pend_q & rd_owner_q;
    assign core_rdata  = mem_rdata;
    assign dbg_rdata   = mem_rdata;

endmodule
